fetch_buffer: RTL

Instruction buffer between the fetch stage (PC register plus byte-addressed instruction memory) and the decode stage. Captures each fetched {PC, instruction} pair into a small FIFO and presents it to decode under a valid/ready handshake. Throttles PC advance when decode stalls, and discards all buffered work on a taken branch (`pcsrc`).

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_buffer_if.sv | 41 ++++
 rtl/fetch_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package    : cpu_pkg
// Purpose    : Shared CPU constants and types used by the fetch buffer and by
//              the decode pipeline register.
// Contents   : XLEN, NOP_INSTR, fetch_pkt_t ({pc, instr}).
// Revision   : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- shown to decode whenever no valid entry is present.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface  : fetch_buffer_if
// Purpose    : Fetch-side push channel, decode-side pop channel, branch flush
//              and occupancy of the fetch buffer.
// Modports   : slave  - the buffer itself
//              master - the fetch/decode environment around it
// Signals    : in_valid/in_pc/in_instr/in_ready  push handshake
//              out_valid/out_pc/out_instr/out_ready pop handshake
//              flush (taken branch), count (occupancy)
// Revision   : 1.0  initial release
// ============================================================================
interface fetch_buffer_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_instr;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_instr;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

endinterface : fetch_buffer_if
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module     : fetch_buffer
// Purpose    : DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode.
//              in_ready throttles PC advance; flush (taken branch) empties the
//              buffer with priority over any concurrent push or pop.
// Ports      : clk   - rising-edge clock
//              reset - asynchronous, active-low
//              bus   - fetch_buffer_if.slave (push/pop handshakes, flush, count)
// Revision   : 1.0  initial release
// ============================================================================
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic          clk,
  input  logic          reset,
  fetch_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage is intentionally not reset: contents are only observed when
  // count_q says the entry is live.
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Handshake flags come from registered occupancy only, so in_ready has no
  // combinational path from out_ready.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign push = bus.in_valid && !full && !bus.flush;
  assign pop  = !empty && bus.out_ready && !bus.flush;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.count     = count_q;
  assign bus.out_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign bus.out_instr = empty ? XLEN'(NOP_INSTR) : instr_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps on its own.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
      instr_mem_q[wr_ptr_q] <= bus.in_instr;
    end
  end

endmodule : fetch_buffer
`default_nettype wire
